// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request and result handshake.
//   Single-cycle ops (and, or, add, xor, andn, orn, sub, slt, sltu, 12-15)
//   produce a result one cycle after accept. mul/divu/remu take WIDTH
//   iteration cycles: one shift-add step for mul, or one restoring
//   shift-subtract step for div/rem.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   invalid / inready     request handshake (inready high only in IDLE)
//   srca, srcb            operands
//   alucontrol            operation select
//   outvalid / outready   result handshake (outvalid high only in DONE)
//   aluresult, zero, ovf  registered result and flags, updated on DONE entry
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             invalid,
  output logic             inready,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       alucontrol,
  output logic             outvalid,
  input  logic             outready,
  output logic [WIDTH-1:0] aluresult,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_XOR  = 4'd3,
    OP_ANDN = 4'd4,
    OP_ORN  = 4'd5,
    OP_SUB  = 4'd6,
    OP_SLT  = 4'd7,
    OP_SLTU = 4'd8,
    OP_MUL  = 4'd9,
    OP_DIVU = 4'd10,
    OP_REMU = 4'd11
  } alu_op_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  alu_op_e         op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;     // mul: multiplicand; div: dividend/quotient
  logic [WIDTH-1:0] b_q, b_d;     // mul: multiplier;   div: divisor
  logic [WIDTH-1:0] acc_q, acc_d; // mul: product;      div: partial remainder
  logic [WIDTH-1:0] res_q, res_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;

  // Single-cycle datapath
  logic [WIDTH-1:0] sum, dif, sc_res;
  logic             sc_ovf, slt_lt;

  always_comb begin
    sum    = srca + srcb;
    dif    = srca - srcb;
    // Sign of the (WIDTH+1)-bit difference of sign-extended operands:
    // differing signs decide directly, otherwise the WIDTH-bit difference
    // cannot overflow and its sign is the answer.
    slt_lt = (srca[WIDTH-1] != srcb[WIDTH-1]) ? srca[WIDTH-1] : dif[WIDTH-1];
    sc_res = '0;
    sc_ovf = 1'b0;
    case (alu_op_e'(alucontrol))
      OP_AND:  sc_res = srca & srcb;
      OP_OR:   sc_res = srca | srcb;
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (srca[WIDTH-1] == srcb[WIDTH-1]) && (sum[WIDTH-1] != srca[WIDTH-1]);
      end
      OP_XOR:  sc_res = srca ^ srcb;
      OP_ANDN: sc_res = srca & ~srcb;
      OP_ORN:  sc_res = srca | ~srcb;
      OP_SUB: begin
        sc_res = dif;
        sc_ovf = (srca[WIDTH-1] != srcb[WIDTH-1]) && (dif[WIDTH-1] != srca[WIDTH-1]);
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, slt_lt};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (srca < srcb)};
      default: sc_res = '0;
    endcase
  end

  // Iterative datapath: one step per BUSY cycle
  logic [WIDTH-1:0] mul_acc_nxt, rem_nxt, quo_nxt;
  logic [WIDTH:0]   rem_sh, trial;

  always_comb begin
    mul_acc_nxt = acc_q + (b_q[0] ? a_q : '0);
    rem_sh      = {acc_q, a_q[WIDTH-1]};
    trial       = rem_sh - {1'b0, b_q};
    // A zero divisor never borrows, so the quotient fills with ones and
    // the remainder ends up equal to the dividend.
    if (trial[WIDTH]) begin
      rem_nxt = rem_sh[WIDTH-1:0];
      quo_nxt = {a_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {a_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (invalid) begin
          if ((alucontrol == OP_MUL) || (alucontrol == OP_DIVU) || (alucontrol == OP_REMU)) begin
            op_d    = alu_op_e'(alucontrol);
            a_d     = srca;
            b_d     = srcb;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            res_d   = sc_res;
            zero_d  = (sc_res == '0);
            ovf_d   = sc_ovf;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        if (op_q == OP_MUL) begin
          acc_d = mul_acc_nxt;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end else begin
          acc_d = rem_nxt;
          a_d   = quo_nxt;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = DONE;
          case (op_q)
            OP_MUL:  res_d = mul_acc_nxt;
            OP_DIVU: res_d = quo_nxt;
            default: res_d = rem_nxt;
          endcase
          case (op_q)
            OP_MUL:  zero_d = (mul_acc_nxt == '0);
            OP_DIVU: zero_d = (quo_nxt == '0);
            default: zero_d = (rem_nxt == '0);
          endcase
        end
      end
      DONE: begin
        if (outready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_AND;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign inready   = (state_q == IDLE);
  assign outvalid  = (state_q == DONE);
  assign aluresult = res_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq at WIDTH=32.
module tb_alu_seq;

  logic        clk;
  logic        reset_n;
  logic        invalid;
  logic        inready;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [3:0]  alucontrol;
  logic        outvalid;
  logic        outready;
  logic [31:0] aluresult;
  logic        zero;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .invalid    (invalid),
    .inready    (inready),
    .srca       (srca),
    .srcb       (srcb),
    .alucontrol (alucontrol),
    .outvalid   (outvalid),
    .outready   (outready),
    .aluresult  (aluresult),
    .zero       (zero),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request, let one rising edge accept it, return #1 after it.
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alucontrol = op;
    srca       = a;
    srcb       = b;
    invalid    = 1'b1;
    @(posedge clk); #1;
    invalid    = 1'b0;
  endtask

  task automatic finish_op();
    outready = 1'b1;
    @(posedge clk); #1;
    outready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; invalid = 1'b0; outready = 1'b0;
    srca = '0; srcb = '0; alucontrol = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (aluresult !== 32'h0) begin failures++; $display("FAIL reset_result got %h expected %h", aluresult, 32'h0); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got %b expected 1", zero); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got %b expected 0", ovf); end
    checks++; if (outvalid !== 1'b0) begin failures++; $display("FAIL reset_outvalid got %b expected 0", outvalid); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (inready !== 1'b1) begin failures++; $display("FAIL reset_inready got %b expected 1", inready); end
    // First edge after release accepts: add 0x7FFFFFFF + 1 with outready held high.
    outready = 1'b1;
    start_op(4'd2, 32'h7FFF_FFFF, 32'h1);
    checks++; if (outvalid !== 1'b1) begin failures++; $display("FAIL add_latency outvalid got %b expected 1", outvalid); end
    checks++; if (aluresult !== 32'h8000_0000) begin failures++; $display("FAIL add_ovf_result got %h expected %h", aluresult, 32'h8000_0000); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL add_ovf_flag got %b expected 1", ovf); end
    checks++; if (zero !== 1'b0) begin failures++; $display("FAIL add_ovf_zero got %b expected 0", zero); end
    @(posedge clk); #1;
    outready = 1'b0;
    checks++; if (inready !== 1'b1 || outvalid !== 1'b0) begin failures++; $display("FAIL add_release inready/outvalid got %b/%b expected 1/0", inready, outvalid); end
    checks++; if (aluresult !== 32'h8000_0000) begin failures++; $display("FAIL idle_retain got %h expected %h", aluresult, 32'h8000_0000); end
  endtask

  task automatic test_single_cycle();
    logic [3:0]  ops [12];
    logic [31:0] as  [12];
    logic [31:0] bs  [12];
    logic [31:0] rs  [12];
    logic        vs  [12];
    ops = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12, 4'd6, 4'd2, 4'd7};
    as  = '{32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234,
            32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000,
            32'hFFFF_FFFF, 32'h8000_0000};
    bs  = '{32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00,
            32'd5, 32'd1, 32'd1, 32'h9ABC_DEF0, 32'd1,
            32'd1, 32'h7FFF_FFFF};
    rs  = '{32'h00F0_1200, 32'hFFF0_FF34, 32'hFF00_ED34, 32'hF000_0034, 32'hF0FF_12FF,
            32'd0, 32'd1, 32'd0, 32'd0, 32'h7FFF_FFFF,
            32'd0, 32'd1};
    vs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      start_op(ops[i], as[i], bs[i]);
      checks++; if (outvalid !== 1'b1) begin failures++; $display("FAIL sc%0d_outvalid got %b expected 1", i, outvalid); end
      checks++; if (aluresult !== rs[i]) begin failures++; $display("FAIL sc%0d_result op %0d got %h expected %h", i, ops[i], aluresult, rs[i]); end
      checks++; if (zero !== (rs[i] == 32'd0)) begin failures++; $display("FAIL sc%0d_zero got %b expected %b", i, zero, (rs[i] == 32'd0)); end
      checks++; if (ovf !== vs[i]) begin failures++; $display("FAIL sc%0d_ovf got %b expected %b", i, ovf, vs[i]); end
      finish_op();
    end
  endtask

  task automatic test_multi_cycle();
    logic [3:0]  ops [6];
    logic [31:0] as  [6];
    logic [31:0] bs  [6];
    logic [31:0] rs  [6];
    int          lat;
    logic        busy_ok;
    ops = '{4'd9, 4'd9, 4'd10, 4'd11, 4'd10, 4'd11};
    as  = '{32'h0001_0000, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'd9, 32'd9};
    bs  = '{32'h0001_0003, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd0, 32'd0};
    rs  = '{32'h0003_0000, 32'h0000_0001, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};
    for (int i = 0; i < 6; i++) begin
      start_op(ops[i], as[i], bs[i]);
      lat = 1;
      busy_ok = 1'b1;
      while (outvalid !== 1'b1 && lat < 200) begin
        if (inready !== 1'b0) busy_ok = 1'b0;
        if (lat == 1) begin
          // Inputs must be ignored while iterating.
          invalid = 1'b1; alucontrol = 4'd2; srca = 32'hDEAD_BEEF; srcb = 32'h1234_5678;
        end
        @(posedge clk); #1;
        lat++;
      end
      invalid = 1'b0;
      checks++; if (lat !== 33) begin failures++; $display("FAIL mc%0d_latency got %0d expected 33", i, lat); end
      checks++; if (busy_ok !== 1'b1 || inready !== 1'b0) begin failures++; $display("FAIL mc%0d_inready_busy got %b/%b expected 1/0", i, busy_ok, inready); end
      checks++; if (aluresult !== rs[i]) begin failures++; $display("FAIL mc%0d_result op %0d got %h expected %h", i, ops[i], aluresult, rs[i]); end
      checks++; if (zero !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL mc%0d_flags zero/ovf got %b/%b expected 0/0", i, zero, ovf); end
      finish_op();
    end
  endtask

  task automatic test_hold();
    logic stable_ok;
    start_op(4'd0, 32'hFFFF_0000, 32'h0F0F_0F0F);
    // A pending request must not be taken while the result is unconsumed.
    invalid = 1'b1; alucontrol = 4'd2; srca = 32'd1; srcb = 32'd1;
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (outvalid !== 1'b1 || inready !== 1'b0 || aluresult !== 32'h0F0F_0000) stable_ok = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (stable_ok !== 1'b1) begin failures++; $display("FAIL hold_stable got %b expected 1", stable_ok); end
    checks++; if (aluresult !== 32'h0F0F_0000) begin failures++; $display("FAIL hold_result got %h expected %h", aluresult, 32'h0F0F_0000); end
    outready = 1'b1;
    @(posedge clk); #1;
    outready = 1'b0;
    invalid  = 1'b0;
    checks++; if (inready !== 1'b1 || outvalid !== 1'b0) begin failures++; $display("FAIL hold_release inready/outvalid got %b/%b expected 1/0", inready, outvalid); end
    checks++; if (aluresult !== 32'h0F0F_0000) begin failures++; $display("FAIL hold_no_accept got %h expected %h", aluresult, 32'h0F0F_0000); end
  endtask

  task automatic test_reset_abort();
    logic quiet_ok;
    start_op(4'd10, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    checks++; if (outvalid !== 1'b0 || aluresult !== 32'h0 || zero !== 1'b1) begin failures++; $display("FAIL abort_async outvalid/result/zero got %b/%h/%b expected 0/0/1", outvalid, aluresult, zero); end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    quiet_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (outvalid !== 1'b0 || aluresult !== 32'h0 || inready !== 1'b1) quiet_ok = 1'b0;
    end
    checks++; if (quiet_ok !== 1'b1) begin failures++; $display("FAIL abort_no_result got %b expected 1", quiet_ok); end
    start_op(4'd2, 32'd2, 32'd3);
    checks++; if (outvalid !== 1'b1 || aluresult !== 32'd5) begin failures++; $display("FAIL abort_then_add outvalid/result got %b/%h expected 1/%h", outvalid, aluresult, 32'd5); end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_multi_cycle();
    test_hold();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; legal range 4..64.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset is asynchronous and active-low.
REQ-004 invalid  input  1  operation request valid.
REQ-005 inready  output  1  block can accept a request.
REQ-006 srca  input  WIDTH  operand A.
REQ-007 srcb  input  WIDTH  operand B.
REQ-008 alucontrol  input  4  operation select.
REQ-009 outvalid  output  1  result valid.
REQ-010 outready  input  1  consumer accepts result.
REQ-011 aluresult  output  WIDTH  registered result.
REQ-012 zero  output  1  registered; 1 iff aluresult == 0.
REQ-013 ovf  output  1  registered signed overflow flag; 1 only for add/sub overflow, else 0.

Function
REQ-014 alucontrol encoding: 0 and; 1 or; 2 add; 3 xor; 4 a & ~b; 5 a | ~b; 6 sub; 7 slt signed; 8 sltu unsigned; 9 mul (low WIDTH bits); 10 divu quotient; 11 remu; 12-15 result 0, zero 1, ovf 0.
REQ-015 Add/sub/and/or/xor wrap modulo 2^WIDTH; ovf = operands' sign rule (add: same signs, result sign differs; sub: signs differ, result sign differs from srca).
REQ-016 slt compares srca/srcb as two's complement with full-width-plus-one subtraction, no overflow error; result 1 or 0 zero-extended.
REQ-017 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-018 inready = 1 exactly in IDLE; request accepted on an edge where invalid & inready.
REQ-019 Single-cycle ops (0-8, 12-15): IDLE -> DONE on accept; outvalid high the cycle after accept (latency 1).
REQ-020 Multi-cycle ops (9-11): operands and op latched on accept; IDLE -> BUSY; WIDTH iteration cycles (one shift-add or restoring shift-subtract step per cycle); then DONE; outvalid high WIDTH+1 cycles after accept.
REQ-021 BUSY iteration counter counts 0..WIDTH-1; ignores invalid, srca, srcb, alucontrol changes.
REQ-022 DONE: aluresult, zero, ovf held stable while outvalid & ~outready.
REQ-023 DONE -> IDLE on edge with outready = 1; no same-cycle new accept (inready low in DONE).
REQ-024 outvalid = 1 exactly in DONE.
REQ-025 Divide by zero: divu result all ones, remu result = srca, completes in normal WIDTH+1 latency, no error flag.
REQ-026 mul: unsigned product, upper WIDTH bits discarded; ovf 0.
REQ-027 aluresult, zero, ovf change only on entry to DONE; stable in IDLE/BUSY (retain last result).

Reset
REQ-028 reset_n low asynchronously forces: state IDLE, counter 0, aluresult 0, zero 1, ovf 0, outvalid 0, inready 1 (after deassertion).
REQ-029 Reset mid-BUSY or mid-DONE aborts the operation; no result is produced after release.
REQ-030 First accept possible on the first rising edge after reset_n deasserted.

Verification (WIDTH=32)
REQ-031 add 0x7FFFFFFF + 1, outready=1 -> outvalid 1 cycle later, aluresult 0x80000000, ovf 1, zero 0.
REQ-032 sub 5-5 -> aluresult 0, zero 1, ovf 0; slt 0xFFFFFFFF vs 1 -> 1; sltu same operands -> 0.
REQ-033 mul 0x10000 * 0x10003 -> aluresult 0x00030000 after 33 cycles, inready 0 during cycles 1..33.
REQ-034 divu 100/7 -> 14; remu 100/7 -> 2; divu 9/0 -> 0xFFFFFFFF; remu 9/0 -> 9.
REQ-035 and result held with outready=0 for 5 cycles -> aluresult/outvalid stable, inready 0; outready=1 -> IDLE next edge.
REQ-036 reset_n pulsed low at cycle 10 of a divu -> outvalid never rises for it, aluresult 0, zero 1; following add 2+3 -> 5.
